// File: rtl/irq_controller_if.sv
// Bus bundle between the interrupt controller (slave) and the CPU/configuration side (master).
interface irq_controller_if;
  logic [7:0]  irq_src;
  logic        reset_irq;
  logic        irq;
  logic [15:0] irq_addr;
  logic [2:0]  irq_id;
  logic [7:0]  pending;
  logic        cfg_write;
  logic        cfg_addr;
  logic [15:0] cfg_wdata;

  modport master (
    output irq_src, reset_irq, cfg_write, cfg_addr, cfg_wdata,
    input  irq, irq_addr, irq_id, pending
  );

  modport slave (
    input  irq_src, reset_irq, cfg_write, cfg_addr, cfg_wdata,
    output irq, irq_addr, irq_id, pending
  );
endinterface

// File: rtl/irq_controller.sv
// Eight-source edge-latched priority interrupt controller with a vectored handler address.
// Optional mask register is built in when the macro IRQ_MASK_EN is defined.
module irq_controller (
  input  logic              clock,
  input  logic              reset,
  irq_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t      state_r;
  logic        irq_r;
  logic [2:0]  irq_id_r;
  logic [7:0]  pending_r;
  logic [7:0]  prev_r;
  logic [15:0] vector_base_r;
  logic [7:0]  mask_s;
  logic [7:0]  rise_s;
  logic [7:0]  eligible_s;
  logic [7:0]  clear_s;
  logic [2:0]  winner_s;

`ifdef IRQ_MASK_EN
  logic [7:0] mask_r;

  // Mask register; only the low byte of the write data is meaningful.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_r <= 8'hFF;
    end else if (bus.cfg_write && bus.cfg_addr) begin
      mask_r <= bus.cfg_wdata[7:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  assign mask_s = mask_r;
`else
  assign mask_s = 8'hFF;
`endif

  assign rise_s     = bus.irq_src & ~prev_r;
  assign eligible_s = pending_r & mask_s;

  // Lowest-index eligible source wins.
  always_comb begin
    winner_s = 3'd0;
    casez (eligible_s)
      8'b???????1: winner_s = 3'd0;
      8'b??????10: winner_s = 3'd1;
      8'b?????100: winner_s = 3'd2;
      8'b????1000: winner_s = 3'd3;
      8'b???10000: winner_s = 3'd4;
      8'b??100000: winner_s = 3'd5;
      8'b?1000000: winner_s = 3'd6;
      8'b10000000: winner_s = 3'd7;
      default:     winner_s = 3'd0;
    endcase
  end

  // Acknowledge clears only the source being served, and only while requesting.
  always_comb begin
    clear_s = 8'h00;
    if (state_r == REQ && bus.reset_irq) begin
      clear_s[irq_id_r] = 1'b1;
    end else begin
      clear_s = 8'h00;
    end
  end

  // Edge detect and pending latches; a coincident new edge beats the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_r    <= 8'h00;
      pending_r <= 8'h00;
    end else begin
      prev_r    <= bus.irq_src;
      pending_r <= (pending_r & ~clear_s) | rise_s;
    end
  end

  // Vector base register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vector_base_r <= 16'hFF00;
    end else if (bus.cfg_write && !bus.cfg_addr) begin
      vector_base_r <= bus.cfg_wdata;
    end else begin
      vector_base_r <= vector_base_r;
    end
  end

  // Service FSM; irq and irq_id are registered and frozen while requesting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      irq_r    <= 1'b0;
      irq_id_r <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (eligible_s != 8'h00) begin
            state_r  <= REQ;
            irq_r    <= 1'b1;
            irq_id_r <= winner_s;
          end else begin
            state_r  <= IDLE;
            irq_r    <= 1'b0;
          end
        end
        REQ: begin
          if (bus.reset_irq) begin
            state_r <= HOLDOFF;
            irq_r   <= 1'b0;
          end else begin
            state_r <= REQ;
            irq_r   <= 1'b1;
          end
        end
        HOLDOFF: begin
          state_r <= IDLE;
          irq_r   <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          irq_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq      = irq_r;
  assign bus.irq_id   = irq_id_r;
  assign bus.pending  = pending_r;
  assign bus.irq_addr = vector_base_r + {10'b0, irq_id_r, 3'b000};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the service rules.
module tb_irq_controller;

  logic clock;
  logic reset;
  irq_controller_if bus ();

  irq_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [7:0]  m_pend;
  logic [7:0]  m_prev;
  logic [7:0]  m_mask;
  logic [15:0] m_vbase;
  logic [2:0]  m_id;
  bit          m_active;
  int          m_cool;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend   = 8'h00;
    m_prev   = 8'h00;
    m_mask   = 8'hFF;
    m_vbase  = 16'hFF00;
    m_id     = 3'd0;
    m_active = 1'b0;
    m_cool   = 0;
  endtask

  task automatic model_step(input logic [7:0] src, input logic ack, input logic cw,
                            input logic ca, input logic [15:0] wd);
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] elig;
    rise = src & ~m_prev;
    clr  = 8'h00;
    if (m_active && ack) clr[m_id] = 1'b1;
    elig = m_pend & m_mask;
    if (m_active) begin
      if (ack) begin
        m_active = 1'b0;
        m_cool   = 1;
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (elig != 8'h00) begin
      for (int i = 0; i < 8; i++) begin
        if (elig[i]) begin
          m_id = 3'(i);
          break;
        end
      end
      m_active = 1'b1;
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = src;
    if (cw && !ca) m_vbase = wd;
`ifdef IRQ_MASK_EN
    if (cw && ca) m_mask = wd[7:0];
`endif
  endtask

  task automatic step();
    logic [7:0]  src;
    logic        ack;
    logic        cw;
    logic        ca;
    logic [15:0] wd;
    logic [15:0] exp_addr;
    src = bus.irq_src;
    ack = bus.reset_irq;
    cw  = bus.cfg_write;
    ca  = bus.cfg_addr;
    wd  = bus.cfg_wdata;
    @(posedge clock);
    model_step(src, ack, cw, ca, wd);
    #1;
    exp_addr = m_vbase + 16'(m_id) * 16'd8;
    check("irq",      32'(bus.irq),      32'(m_active));
    check("irq_id",   32'(bus.irq_id),   32'(m_id));
    check("irq_addr", 32'(bus.irq_addr), 32'(exp_addr));
    check("pending",  32'(bus.pending),  32'(m_pend));
  endtask

  task automatic ack_pulse();
    bus.reset_irq = 1'b1;
    step();
    bus.reset_irq = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    bus.irq_src = v;
    step();
    bus.irq_src = 8'h00;
  endtask

  int svc;
  logic last_irq;

  initial begin
    reset         = 1'b0;
    bus.irq_src   = 8'h00;
    bus.reset_irq = 1'b0;
    bus.cfg_write = 1'b0;
    bus.cfg_addr  = 1'b0;
    bus.cfg_wdata = 16'h0000;
    #11;
    check("rst_irq",     32'(bus.irq),      32'd0);
    check("rst_id",      32'(bus.irq_id),   32'd0);
    check("rst_pending", 32'(bus.pending),  32'd0);
    check("rst_addr",    32'(bus.irq_addr), 32'h0000FF00);
    model_reset();
    #1 reset = 1'b1;

    // Single source, two-cycle latency
    pulse_src(8'h08);
    check("single_lat1", 32'(bus.irq), 32'd0);
    step();
    check("single_irq",  32'(bus.irq),      32'd1);
    check("single_id",   32'(bus.irq_id),   32'd3);
    check("single_addr", 32'(bus.irq_addr), 32'h0000FF18);
    ack_pulse();
    check("single_ack_irq", 32'(bus.irq),     32'd0);
    check("single_ack_pnd", 32'(bus.pending), 32'd0);
    step(); step();

    // Priority, holdoff and frozen id
    pulse_src(8'h22);
    step();
    check("prio_id",   32'(bus.irq_id),   32'd1);
    check("prio_addr", 32'(bus.irq_addr), 32'h0000FF08);
    ack_pulse();
    check("prio_hold", 32'(bus.irq), 32'd0);
    step();
    check("prio_idle", 32'(bus.irq), 32'd0);
    step();
    check("prio2_irq",  32'(bus.irq),      32'd1);
    check("prio2_id",   32'(bus.irq_id),   32'd5);
    check("prio2_addr", 32'(bus.irq_addr), 32'h0000FF28);
    pulse_src(8'h01);
    step();
    check("freeze_id",  32'(bus.irq_id), 32'd5);
    check("freeze_irq", 32'(bus.irq),    32'd1);
    ack_pulse(); step(); step();
    check("after_freeze_id", 32'(bus.irq_id), 32'd0);
    ack_pulse(); step(); step();

    // Vector base wrap and live update during REQ
    bus.cfg_write = 1'b1; bus.cfg_addr = 1'b0; bus.cfg_wdata = 16'hFFF0;
    pulse_src(8'h80);
    bus.cfg_write = 1'b0;
    step();
    check("wrap_id",   32'(bus.irq_id),   32'd7);
    check("wrap_addr", 32'(bus.irq_addr), 32'h00000028);
    bus.cfg_write = 1'b1; bus.cfg_wdata = 16'hFF00;
    step();
    bus.cfg_write = 1'b0;
    check("live_addr", 32'(bus.irq_addr), 32'h0000FF38);
    ack_pulse(); step(); step();

`ifdef IRQ_MASK_EN
    bus.cfg_write = 1'b1; bus.cfg_addr = 1'b1; bus.cfg_wdata = 16'hABFE;
    step();
    bus.cfg_write = 1'b0;
    pulse_src(8'h01);
    step(); step();
    check("mask_irq",     32'(bus.irq),     32'd0);
    check("mask_pending", 32'(bus.pending), 32'h00000001);
    bus.cfg_write = 1'b1; bus.cfg_wdata = 16'h00FF;
    step();
    bus.cfg_write = 1'b0;
    step();
    check("unmask_irq", 32'(bus.irq),    32'd1);
    check("unmask_id",  32'(bus.irq_id), 32'd0);
    bus.cfg_write = 1'b1; bus.cfg_wdata = 16'h00FE;
    step();
    step();
    check("mask_active_irq", 32'(bus.irq), 32'd1);
    bus.cfg_wdata = 16'h00FF;
    ack_pulse();
    bus.cfg_write = 1'b0;
    step(); step();
`endif

    // Ack while idle is ignored
    ack_pulse();
    check("idle_ack_irq", 32'(bus.irq),     32'd0);
    check("idle_ack_pnd", 32'(bus.pending), 32'd0);

    // Held level gives one service only
    svc = 0;
    last_irq = 1'b0;
    bus.irq_src = 8'h04;
    for (int i = 0; i < 24; i++) begin
      if (i == 20) bus.irq_src = 8'h00;
      step();
      if (bus.irq && !last_irq) svc++;
      last_irq = bus.irq;
      bus.reset_irq = m_active;
    end
    bus.reset_irq = 1'b0;
    check("hold_once", 32'(svc), 32'd1);
    step(); step();

    // New edge coinciding with its own ack keeps it pending
    pulse_src(8'h04);
    step();
    check("reedge_id", 32'(bus.irq_id), 32'd2);
    bus.irq_src = 8'h04; bus.reset_irq = 1'b1;
    step();
    bus.irq_src = 8'h00; bus.reset_irq = 1'b0;
    check("reedge_pnd", 32'(bus.pending), 32'h00000004);
    step(); step();
    check("reedge_irq2", 32'(bus.irq),    32'd1);
    check("reedge_id2",  32'(bus.irq_id), 32'd2);
    ack_pulse(); step(); step();

    // Asynchronous reset in the middle of a request
    pulse_src(8'h08);
    step();
    check("areset_pre", 32'(bus.irq), 32'd1);
    bus.irq_src = 8'h10;
    #2 reset = 1'b0;
    #1;
    check("areset_irq", 32'(bus.irq),     32'd0);
    check("areset_pnd", 32'(bus.pending), 32'd0);
    model_reset();
    #10 reset = 1'b1;
    step();
    check("post_reset_edge", 32'(bus.pending), 32'h00000010);
    bus.irq_src = 8'h00;
    step();
    check("post_reset_id", 32'(bus.irq_id), 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.irq_src   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.reset_irq = (m_active && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 15) == 0);
      bus.cfg_write = ($urandom_range(0, 15) == 0);
      bus.cfg_addr  = 1'($urandom);
      bus.cfg_wdata = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port irq_src  input  8  interrupt source lines, synchronous to clock; index 0 is highest priority.
REQ-004 SHALL have port reset_irq  input  1  CPU acknowledge; one-cycle pulse, sampled on the clock edge.
REQ-005 SHALL have port irq  output  1  interrupt request to the CPU control path.
REQ-006 SHALL have port irq_addr  output  16  handler address; the CPU loads it into PC.
REQ-007 SHALL have port irq_id  output  3  index of the source currently being served.
REQ-008 SHALL have port pending  output  8  pending-latch status.
REQ-009 SHALL have port cfg_write  input  1  configuration write strobe.
REQ-010 SHALL have port cfg_addr  input  1  configuration register select: 0 = vector_base, 1 = mask.
REQ-011 SHALL have port cfg_wdata  input  16  configuration write data.

Function
REQ-012 Edge detection: per-source previous-value register; pending[i] sets on the cycle irq_src[i] goes 0->1; a held-high level SHALL set it only once.
REQ-013 Eligible set = pending & mask[7:0]; winner = lowest-index eligible bit.
REQ-014 FSM states: IDLE, REQ, HOLDOFF.
REQ-015 IDLE: when eligible set is nonzero, latch winner into irq_id and go to REQ on the next edge; otherwise stay in IDLE.
REQ-016 REQ: irq = 1; irq_id and irq_addr stay frozen even if higher-priority sources pend.
REQ-017 REQ with reset_irq = 1: clear pending[irq_id] and go to HOLDOFF.
REQ-018 HOLDOFF: irq = 0 for exactly one cycle, then IDLE. This prevents re-entry while the CPU returns to its reset state.
REQ-019 irq = 1 only in REQ; irq rises one cycle after the pending edge is latched. Minimum latency from source edge to irq is 2 cycles.
REQ-020 irq_addr = vector_base + {10'b0, irq_id, 3'b000}, computed modulo 2^16 (wraps).
REQ-021 reset_irq outside REQ SHALL be ignored.
REQ-022 If a new edge on irq_src[irq_id] coincides with its clear, set SHALL win and pending[irq_id] stays 1.
REQ-023 cfg_write with cfg_addr = 0: vector_base <= cfg_wdata on that edge. A write during REQ changes irq_addr immediately.
REQ-024 Masking SHALL NOT block latching: a masked source stays pending and is served once unmasked.
REQ-025 Clearing the mask bit of the active source during REQ SHALL NOT deassert irq.

Reset
REQ-026 On reset low, all of the following SHALL clear asynchronously:
- FSM = IDLE, irq = 0, irq_id = 0, pending = 0.
- Edge-detect registers = 0.
- vector_base = 16'hFF00, mask = 8'hFF.
REQ-027 Reset mid-REQ SHALL drop irq immediately and lose all pending requests.
REQ-028 The first edge after reset release SHALL detect irq_src bits already high as rising edges.

Configuration
REQ-029 Macro IRQ_MASK_EN:
- Defined: mask register exists; cfg_addr = 1 writes mask <= cfg_wdata[7:0]; bits [15:8] are ignored.
- Undefined: no mask register; mask is treated as 8'hFF; cfg_addr = 1 writes have no effect.

Verification
REQ-030 Single source: after reset, pulse irq_src[3] -> irq = 1 two cycles later, irq_id = 3, irq_addr = 16'hFF18. Pulse reset_irq -> irq = 0 for at least one cycle, pending = 0.
REQ-031 Priority: pulse irq_src[5] and irq_src[1] in the same cycle -> serve id 1 (addr 16'hFF08). Ack -> after HOLDOFF, irq re-asserts with id 5 (addr 16'hFF28).
REQ-032 Wrap and config: write vector_base = 16'hFFF0, pend source 7 -> irq_addr = 16'h0028.
REQ-033 Mask (IRQ_MASK_EN): write mask = 8'hFE, pulse irq_src[0] -> irq stays 0 and pending = 8'h01. Write mask = 8'hFF -> irq = 1, id 0.
REQ-034 Boundary cases:
- Hold irq_src[2] high for 20 cycles -> exactly one service.
- reset_irq while IDLE -> no state change.
- Re-edge on irq_src[2] coinciding with its ack -> pending[2] = 1 and a second service follows.
REQ-035 Async reset: assert reset mid-REQ -> irq = 0 with no clock edge required; pending = 0.
